// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the BCD <-> binary conversion paths.
// The binary-to-BCD side uses threshold 5 / add 3; this side uses threshold 8 / subtract 3.
package bcd_pkg;

    localparam int         DIGIT_W     = 4;
    localparam logic [3:0] CORR_THRESH = 4'd8;
    localparam logic [3:0] CORR_SUB    = 4'd3;
    localparam logic [3:0] BCD_MAX     = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

endpackage

// File: rtl/bcd_sub3_cell.sv
// One BCD digit correction step of reverse double dabble: digits >= 8 after a right shift lose 3.
module bcd_sub3_cell
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] d,
    output logic [DIGIT_W-1:0] q
);

    assign q = (d >= CORR_THRESH) ? d - CORR_SUB : d;

endmodule

// File: rtl/bcd_to_bin.sv
// Iterative BCD-to-binary converter: one right shift plus per-digit correction per clock,
// BIN_W iterations per request, start/ready handshake in, single-cycle done pulse out.
module bcd_to_bin
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  in_ready,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int BCD_W  = DIGIT_W * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    state_t              state, state_nxt;
    logic [WORK_W-1:0]   work, work_nxt;
    logic [WORK_W-1:0]   work_shift, work_corr;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [BIN_W-1:0]    bin_nxt;
    logic                err_nxt, done_nxt;
    logic [DIGITS-1:0]   digit_bad;

    // Work register is {bcd field, bin field}; binary bits fall out of the BCD field into bin.
    assign work_shift            = work >> 1;
    assign work_corr[BIN_W-1:0]  = work_shift[BIN_W-1:0];

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_sub3_cell u_cell (
            .d (work_shift[BIN_W + DIGIT_W*i +: DIGIT_W]),
            .q (work_corr [BIN_W + DIGIT_W*i +: DIGIT_W])
        );
        assign digit_bad[i] = bcd_in[DIGIT_W*i +: DIGIT_W] > BCD_MAX;
    end

    assign in_ready = (state == IDLE);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
        state_nxt = state;
        work_nxt  = work;
        cnt_nxt   = cnt;
        bin_nxt   = bin_out;
        err_nxt   = err;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (|digit_bad) begin
                        bin_nxt   = '0;
                        err_nxt   = 1'b1;
                        done_nxt  = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        work_nxt  = {bcd_in, {BIN_W{1'b0}}};
                        cnt_nxt   = '0;
                        state_nxt = CONV;
                    end
                end
            end
            CONV: begin
                work_nxt = work_corr;
                cnt_nxt  = cnt + 1'b1;
                if (cnt == LAST_CNT) begin
                    bin_nxt   = work_corr[BIN_W-1:0];
                    err_nxt   = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            work    <= '0;
            cnt     <= '0;
            bin_out <= '0;
            err     <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            work    <= work_nxt;
            cnt     <= cnt_nxt;
            bin_out <= bin_nxt;
            err     <= err_nxt;
            done    <= done_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed self-checking bench for bcd_to_bin: latency, values, invalid digits, busy handling, reset abort.
module tb_bcd_to_bin;

    localparam int DIGITS   = 4;
    localparam int BIN_W    = 14;
    // Posedges from driving start (accept edge included) until done is seen.
    localparam int CONV_LAT = BIN_W + 1;
    localparam int ERR_LAT  = 1;
    // Accept-to-accept with start held: IDLE + BIN_W CONV cycles + DONE.
    localparam int PERIOD   = BIN_W + 2;
    localparam int TIMEOUT  = 40;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [4*DIGITS-1:0] bcd_in;
    logic                in_ready;
    logic                done;
    logic [BIN_W-1:0]    bin_out;
    logic                err;

    int n_checks = 0;
    int n_pass   = 0;
    int n_done;
    int n_acc;
    int acc[4];

    always #5 clk = ~clk;

    bcd_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bcd_in   (bcd_in),
        .in_ready (in_ready),
        .done     (done),
        .bin_out  (bin_out),
        .err      (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // One request; optionally pulses start with other data mid-conversion, which must be ignored.
    task automatic run_conv(input string tag, input logic [15:0] bcd, input logic [BIN_W-1:0] exp_bin,
                            input logic exp_err, input int exp_lat, input bit inject);
        int lat;
        @(negedge clk);
        check({tag, ".ready"}, 32'(in_ready), 32'd1);
        start  = 1'b1;
        bcd_in = bcd;
        @(negedge clk);
        start  = 1'b0;
        bcd_in = 16'hFFFF;
        lat    = 1;
        while (!done && lat < TIMEOUT) begin
            if (lat == 2) check({tag, ".busy"}, 32'(in_ready), 32'd0);
            if (inject && lat == 3) begin
                start  = 1'b1;
                bcd_in = 16'h0999;
            end
            if (inject && lat == 6) start = 1'b0;
            @(negedge clk);
            lat++;
        end
        check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        check({tag, ".bin"}, 32'(bin_out), 32'(exp_bin));
        check({tag, ".err"}, 32'(err), 32'(exp_err));
        @(negedge clk);
        check({tag, ".pulse"}, 32'(done), 32'd0);
        check({tag, ".held"}, 32'(bin_out), 32'(exp_bin));
        check({tag, ".errheld"}, 32'(err), 32'(exp_err));
        check({tag, ".idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        bcd_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst.ready", 32'(in_ready), 32'd1);
        check("rst.done",  32'(done),     32'd0);
        check("rst.bin",   32'(bin_out),  32'd0);
        check("rst.err",   32'(err),      32'd0);

        run_conv("max",   16'h9999, 14'd9999, 1'b0, CONV_LAT, 1'b0);
        run_conv("zero",  16'h0000, 14'd0,    1'b0, CONV_LAT, 1'b0);
        run_conv("v1234", 16'h1234, 14'd1234, 1'b0, CONV_LAT, 1'b0);
        run_conv("v7",    16'h0007, 14'd7,    1'b0, CONV_LAT, 1'b0);
        run_conv("v89",   16'h0089, 14'd89,   1'b0, CONV_LAT, 1'b0);
        run_conv("badA",  16'h12A4, 14'd0,    1'b1, ERR_LAT,  1'b0);
        run_conv("v50",   16'h0050, 14'd50,   1'b0, CONV_LAT, 1'b0);
        run_conv("badF",  16'h000F, 14'd0,    1'b1, ERR_LAT,  1'b0);
        run_conv("v8000", 16'h8000, 14'd8000, 1'b0, CONV_LAT, 1'b0);

        // start held high: back-to-back accepts, each yielding 4096
        @(negedge clk);
        start  = 1'b1;
        bcd_in = 16'h4096;
        n_acc  = 0;
        n_done = 0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            if (in_ready) begin
                if (n_acc < 4) acc[n_acc] = i;
                n_acc++;
            end
            @(negedge clk);
            if (done) begin
                n_done++;
                check("hold.bin", 32'(bin_out), 32'd4096);
            end
        end
        start = 1'b0;
        check("hold.accepts", 32'(n_acc),  32'd3);
        check("hold.dones",   32'(n_done), 32'd3);
        for (int k = 1; k < 3; k++)
            check("hold.period", 32'(acc[k] - acc[k-1]), 32'(PERIOD));

        // start during conversion with other data is dropped
        run_conv("ign", 16'h0321, 14'd321, 1'b0, CONV_LAT, 1'b1);
        n_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("ign.nodone", 32'(n_done), 32'd0);

        // reset five cycles into a conversion aborts it
        @(negedge clk);
        start  = 1'b1;
        bcd_in = 16'h0555;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort.ready", 32'(in_ready), 32'd1);
        check("abort.bin",   32'(bin_out),  32'd0);
        check("abort.err",   32'(err),      32'd0);
        check("abort.done",  32'(done),     32'd0);
        n_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort.nodone", 32'(n_done), 32'd0);
        run_conv("recover", 16'h0042, 14'd42, 1'b0, CONV_LAT, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
